conv_engine_param: RTL and testbench

Parametrised successor to the fixed 8x8 / 3x3 / 3-channel convolution block. Accepts a full single-channel image and a per-channel kernel set through a valid/ready handshake, captures both internally, and computes every output pixel with one serial signed MAC lane per output channel. Results are held on a flat output bus until the consumer accepts them. The block sits between the image loader and the pooling stage of the accelerator datapath.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_mac_lane.sv | 42 ++++
 rtl/conv_engine_param.sv | 175 +++++++++++++++++
 tb/tb_conv_engine_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the parametrised convolution engine.
// CONV_RELU_EN (optional macro) clamps negative results to zero in each MAC lane.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < v) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (clog2(n) > 32'sd0) ? clog2(n) : 32'sd1;
  endfunction

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 32'sd1;
  endfunction

  // Clamp a sign-extended accumulator value into the signed data_w range.
  function automatic logic signed [63:0] sat_to_data(input logic signed [63:0] v,
                                                     input int data_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (data_w - 32'sd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 32'sd1));
    if (v > max_v) return max_v;
    else if (v < min_v) return min_v;
    else return v;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One serial signed MAC lane: multiply, accumulate with load on tap 0, and form
// the saturated (optionally ReLU-clamped via CONV_RELU_EN) write-back value.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     tap_first,
  input  logic signed [DATA_W-1:0] pix,
  input  logic signed [DATA_W-1:0] wgt,
  output logic        [DATA_W-1:0] wb
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    sum_s;
  logic signed [ACC_W-1:0]    acc_r;

  // Product, running sum and the value to be written back on the last tap.
  always_comb begin
    prod_s = (2*DATA_W)'(pix) * (2*DATA_W)'(wgt);
    if (tap_first) sum_s = ACC_W'(prod_s);
    else           sum_s = acc_r + ACC_W'(prod_s);
`ifdef CONV_RELU_EN
    if (sum_s[ACC_W-1]) wb = {DATA_W{1'b0}};
    else                wb = DATA_W'(sat_to_data(64'(sum_s), DATA_W));
`else
    wb = DATA_W'(sat_to_data(64'(sum_s), DATA_W));
`endif
  end

  // Accumulator register, advanced once per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc_r <= {ACC_W{1'b0}};
    else if (en) acc_r <= sum_s;
    else         acc_r <= acc_r;
  end

endmodule

// File: rtl/conv_engine_param.sv
// Parametrised single-channel-in / OUT_CH-out convolution engine with one MAC lane
// per output channel. Optional macro CONV_RELU_EN enables ReLU on the results.
module conv_engine_param
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int OUT_CH = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE),
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_vld,
  output logic                                  in_rdy,
  input  logic [IMG_W*IMG_H*DATA_W-1:0]         data_lin,
  input  logic [OUT_CH*K*K*DATA_W-1:0]          weight_lin,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [OUT_CH*OUT_H*OUT_W*DATA_W-1:0]  conv_lin
);

  localparam int KW = cnt_w(K);
  localparam int CW = cnt_w(OUT_W);
  localparam int RW = cnt_w(OUT_H);
  localparam int DL = IMG_W*IMG_H*DATA_W;
  localparam int WL = OUT_CH*K*K*DATA_W;
  localparam int CL = OUT_CH*OUT_H*OUT_W*DATA_W;
  localparam logic [KW-1:0] K_LAST = KW'(K - 32'sd1);
  localparam logic [CW-1:0] C_LAST = CW'(OUT_W - 32'sd1);
  localparam logic [RW-1:0] R_LAST = RW'(OUT_H - 32'sd1);

  if ((((IMG_W - K) % STRIDE) != 32'sd0) || (((IMG_H - K) % STRIDE) != 32'sd0)) begin : g_bad_stride
    $fatal(1, "conv_engine_param: STRIDE does not tile the image exactly");
  end
  if (ACC_W < 2*DATA_W + clog2(K*K)) begin : g_bad_acc
    $fatal(1, "conv_engine_param: ACC_W too narrow for full-precision sums");
  end

  conv_state_e             state_r, state_s;
  logic                    in_rdy_r, out_vld_r;
  logic [DL-1:0]           data_r;
  logic [WL-1:0]           weight_r;
  logic [CL-1:0]           conv_r;
  logic [KW-1:0]           kr_r, kc_r;
  logic [CW-1:0]           col_r;
  logic [RW-1:0]           row_r;
  logic                    accept_s, calc_s, tap_first_s, tap_last_s, job_last_s;
  int                      pix_idx_s;
  logic signed [DATA_W-1:0] pix_s;
  logic [DATA_W-1:0]       wb_s [OUT_CH];

  assign accept_s    = (state_r == ST_IDLE) && in_vld;
  assign calc_s      = (state_r == ST_CALC);
  assign tap_first_s = (kr_r == {KW{1'b0}}) && (kc_r == {KW{1'b0}});
  assign tap_last_s  = (kr_r == K_LAST) && (kc_r == K_LAST);
  assign job_last_s  = tap_last_s && (col_r == C_LAST) && (row_r == R_LAST);
  assign in_rdy      = in_rdy_r;
  assign out_vld     = out_vld_r;
  assign conv_lin    = conv_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (in_vld)     state_s = ST_CALC; else state_s = ST_IDLE;
      ST_CALC: if (job_last_s) state_s = ST_DONE; else state_s = ST_CALC;
      ST_DONE: if (out_rdy)    state_s = ST_IDLE; else state_s = ST_DONE;
      default:                 state_s = ST_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      in_rdy_r  <= 1'b1;
      out_vld_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_rdy_r  <= (state_s == ST_IDLE);
      out_vld_r <= (state_s == ST_DONE);
    end
  end

  // Job capture on the accepting edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r   <= {DL{1'b0}};
      weight_r <= {WL{1'b0}};
    end else if (accept_s) begin
      data_r   <= data_lin;
      weight_r <= weight_lin;
    end else begin
      data_r   <= data_r;
      weight_r <= weight_r;
    end
  end

  // Tap (kr,kc) row-major, wrapping into column then row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || accept_s) begin
      kr_r  <= {KW{1'b0}};
      kc_r  <= {KW{1'b0}};
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (calc_s) begin
      if (kc_r == K_LAST) begin
        kc_r <= {KW{1'b0}};
        if (kr_r == K_LAST) begin
          kr_r <= {KW{1'b0}};
          if (col_r == C_LAST) begin
            col_r <= {CW{1'b0}};
            if (row_r == R_LAST) row_r <= {RW{1'b0}};
            else                 row_r <= row_r + RW'(1'b1);
          end else begin
            col_r <= col_r + CW'(1'b1);
          end
        end else begin
          kr_r <= kr_r + KW'(1'b1);
        end
      end else begin
        kc_r <= kc_r + KW'(1'b1);
      end
    end
  end

  // Pixel under the current tap, shared by every lane.
  always_comb begin
    pix_idx_s = (int'(row_r) * STRIDE + int'(kr_r)) * IMG_W
              + int'(col_r) * STRIDE + int'(kc_r);
    pix_s     = data_r[pix_idx_s*DATA_W +: DATA_W];
  end

  for (genvar ch = 0; ch < OUT_CH; ch++) begin : g_lane
    int                       w_idx_s;
    logic signed [DATA_W-1:0] wgt_s;

    // Weight tap for this lane's channel.
    always_comb begin
      w_idx_s = (ch * K + int'(kr_r)) * K + int'(kc_r);
      wgt_s   = weight_r[w_idx_s*DATA_W +: DATA_W];
    end

    conv_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (calc_s),
      .tap_first (tap_first_s),
      .pix       (pix_s),
      .wgt       (wgt_s),
      .wb        (wb_s[ch])
    );
  end

  // Finished windows land in their (ch,r,c) slot; held stable outside CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_r <= {CL{1'b0}};
    end else if (calc_s && tap_last_s) begin
      for (int ch = 0; ch < OUT_CH; ch++)
        conv_r[((ch*OUT_H + int'(row_r))*OUT_W + int'(col_r))*DATA_W +: DATA_W] <= wb_s[ch];
    end else begin
      conv_r <= conv_r;
    end
  end

endmodule

// File: tb/tb_conv_engine_param.sv
// Directed self-checking bench for conv_engine_param (default 8x8 and a 7x7 stride-2 build).
module tb_conv_engine_param;

`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic         clk, rst;
  logic         in_vld, in_rdy, out_vld, out_rdy;
  logic [511:0] data_lin;
  logic [215:0] weight_lin;
  logic [863:0] conv_lin;
  logic         in_vld2, in_rdy2, out_vld2, out_rdy2;
  logic [391:0] data_lin2;
  logic [71:0]  weight_lin2;
  logic [71:0]  conv_lin2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  conv_engine_param dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .data_lin(data_lin), .weight_lin(weight_lin),
    .out_vld(out_vld), .out_rdy(out_rdy), .conv_lin(conv_lin)
  );

  conv_engine_param #(
    .IMG_W(7), .IMG_H(7), .K(3), .STRIDE(2), .OUT_CH(1), .DATA_W(8), .ACC_W(20)
  ) dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld2), .in_rdy(in_rdy2),
    .data_lin(data_lin2), .weight_lin(weight_lin2),
    .out_vld(out_vld2), .out_rdy(out_rdy2), .conv_lin(conv_lin2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_job(input int pix, input int w0, input int w1, input int w2);
    for (int i = 0; i < 64; i++) data_lin[i*8 +: 8] = 8'(pix);
    for (int t = 0; t < 9; t++) begin
      weight_lin[(0*9+t)*8 +: 8] = 8'(w0);
      weight_lin[(1*9+t)*8 +: 8] = 8'(w1);
      weight_lin[(2*9+t)*8 +: 8] = 8'(w2);
    end
  endtask

  task automatic check_grid(input string tag, input int e0, input int e1, input int e2);
    logic [7:0] v;
    int e;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          v = conv_lin[((ch*6+r)*6+c)*8 +: 8];
          e = (ch == 0) ? e0 : (ch == 1) ? e1 : e2;
          chk(tag, int'($signed(v)), e);
        end
  endtask

  // Waits for in_rdy with in_vld already driven, then takes the accepting edge.
  task automatic accept(output int at_edge);
    int n = 0;
    while (in_rdy !== 1'b1 && n < 1000) begin tick; n++; end
    chk("accept_in_rdy", int'(in_rdy), 1);
    tick;
    at_edge = edge_cnt;
  endtask

  task automatic wait_vld;
    int n = 0;
    while (out_vld !== 1'b1 && n < 1000) begin tick; n++; end
    chk("out_vld_within_bound", int'(out_vld), 1);
  endtask

  task automatic release_result;
    out_rdy = 1'b1;
    tick;
    out_rdy = 1'b0;
  endtask

  initial begin
    int bad, ea, eb, n;
    logic [863:0] snap;
    logic [7:0] v;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; data_lin = '0; weight_lin = '0;
    in_vld2 = 1'b0; out_rdy2 = 1'b0; data_lin2 = '0; weight_lin2 = '0;

    // Reset state
    #12;
    chk("reset_in_rdy", int'(in_rdy), 1);
    chk("reset_out_vld", int'(out_vld), 0);
    chk("reset_conv_zero", int'(conv_lin === '0), 1);
    rst = 1'b0;
    tick;

    // All ones: latency 325 edges counting the accepting edge
    set_job(1, 1, 1, 1);
    in_vld = 1'b1;
    accept(ea);
    in_vld = 1'b0;
    bad = 0;
    for (int i = 0; i < 323; i++) begin
      tick;
      if (in_rdy !== 1'b0 || out_vld !== 1'b0) bad++;
    end
    chk("calc_in_rdy_low", bad, 0);
    chk("out_vld_low_edge324", int'(out_vld), 0);
    tick;
    chk("out_vld_high_edge325", int'(out_vld), 1);
    check_grid("ones", 9, 9, 9);

    // Hold result with out_rdy low while a new job is offered
    snap = conv_lin;
    set_job(5, 5, 5, 5);
    in_vld = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (conv_lin !== snap || out_vld !== 1'b1 || in_rdy !== 1'b0) bad++;
    end
    chk("hold_stable", bad, 0);
    in_vld = 1'b0;
    out_rdy = 1'b1;
    tick;
    out_rdy = 1'b0;
    chk("release_out_vld", int'(out_vld), 0);
    chk("release_in_rdy", int'(in_rdy), 1);
    chk("release_conv_kept", int'(conv_lin === snap), 1);

    // Positive saturation
    set_job(127, 127, 127, 127);
    in_vld = 1'b1;
    accept(ea);
    in_vld = 1'b0;
    wait_vld;
    chk("acc_peak", int'(dut.g_lane[0].u_lane.acc_r), 145161);
    check_grid("sat_pos", 127, 127, 127);
    release_result;

    // Negative saturation / ReLU
    set_job(127, -128, 127, -128);
    in_vld = 1'b1;
    accept(ea);
    in_vld = 1'b0;
    wait_vld;
    check_grid("sat_neg", RELU ? 0 : -128, 127, RELU ? 0 : -128);
    release_result;

    // Reset at cycle 100 of a job, then a clean job
    set_job(127, -128, -128, -128);
    in_vld = 1'b1;
    accept(ea);
    in_vld = 1'b0;
    for (int i = 0; i < 99; i++) tick;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_rdy", int'(in_rdy), 1);
    chk("midrst_out_vld", int'(out_vld), 0);
    chk("midrst_conv_zero", int'(conv_lin === '0), 1);
    tick;
    chk("midrst_conv_zero_held", int'(conv_lin === '0), 1);
    #2;
    rst = 1'b0;
    set_job(1, 1, 2, 3);
    in_vld = 1'b1;
    accept(ea);
    in_vld = 1'b0;
    wait_vld;
    check_grid("post_reset", 9, 18, 27);
    release_result;

    // Stride 2 on a 7x7 ramp with a centre-only kernel
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) data_lin2[(r*7+c)*8 +: 8] = 8'(r*8 + c);
    weight_lin2 = '0;
    weight_lin2[4*8 +: 8] = 8'd1;
    in_vld2 = 1'b1;
    n = 0;
    while (in_rdy2 !== 1'b1 && n < 100) begin tick; n++; end
    chk("s2_in_rdy", int'(in_rdy2), 1);
    tick;
    in_vld2 = 1'b0;
    n = 0;
    while (out_vld2 !== 1'b1 && n < 200) begin tick; n++; end
    chk("s2_out_vld", int'(out_vld2), 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        v = conv_lin2[(r*3+c)*8 +: 8];
        chk("s2_slot", int'($signed(v)), (2*r+1)*8 + (2*c+1));
      end
    out_rdy2 = 1'b1;
    tick;
    out_rdy2 = 1'b0;

    // Back-to-back jobs with in_vld and out_rdy held high
    out_rdy = 1'b1;
    set_job(2, 1, -1, 3);
    in_vld = 1'b1;
    accept(ea);
    set_job(1, 14, 15, -15);
    wait_vld;
    check_grid("b2b_a", 18, RELU ? 0 : -18, 54);
    accept(eb);
    chk("b2b_period", eb - ea, 326);
    in_vld = 1'b0;
    wait_vld;
    check_grid("b2b_b", 126, 127, RELU ? 0 : -128);
    tick;
    chk("b2b_done_one_cycle", int'(out_vld), 0);
    out_rdy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
